// File: rtl/spi_pin_regs.sv
// SPI slave register bridge: 8-bit command + 24-bit data frames into pin/LED registers, status + readback on MISO.
// Optional SPI_PIN_INPUT_SYNC_EN adds a 2-FF synchronizer on pin_in before the readback mux.
module spi_pin_regs #(
    parameter int       SYNC_STAGES = 2,
    parameter bit [3:0] STATUS_ID   = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_cs,
    input  logic        cfg_sck,
    input  logic        cfg_si,
    output logic        cfg_so,
    input  logic [23:0] pin_in,
    output logic [23:0] pin_out,
    output logic [23:0] pin_oe,
    output logic [15:0] led_data,
    output logic        wr_strobe,
    output logic [6:0]  wr_addr
);

    typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync;
    logic        cs_q, sck_q;
    logic        cs_s, sck_s, si_s;
    logic        cs_fall, cs_rise, sck_rise, sck_fall;
    state_t      state;
    logic [5:0]  bit_cnt;
    logic [6:0]  cmd_shift;
    logic [7:0]  cmd;
    logic [22:0] data_rx;
    logic [7:0]  stat_shift;
    logic [23:0] data_shift;
    logic        err_sticky, wr_seen;
    logic [23:0] pin_rd, rd_data;
    logic [6:0]  rd_addr;
    logic [23:0] wr_data;
    logic        commit_now;

    // Pad synchronizers carry no reset so a low CS survives reset and selects WAIT_CS.
    always_ff @(posedge clk) begin
        cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cfg_cs};
        sck_sync <= {sck_sync[SYNC_STAGES-2:0], cfg_sck};
        si_sync  <= {si_sync[SYNC_STAGES-2:0], cfg_si};
        cs_q     <= cs_sync[SYNC_STAGES-1];
        sck_q    <= sck_sync[SYNC_STAGES-1];
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign si_s     = si_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_q & ~cs_s;
    assign cs_rise  = ~cs_q & cs_s;
    assign sck_rise = ~sck_q & sck_s;
    assign sck_fall = sck_q & ~sck_s;

`ifdef SPI_PIN_INPUT_SYNC_EN
    logic [23:0] pin_in_q1, pin_in_q2;
    always_ff @(posedge clk) begin
        pin_in_q1 <= pin_in;
        pin_in_q2 <= pin_in_q1;
    end
    assign pin_rd = pin_in_q2;
`else
    assign pin_rd = pin_in;
`endif

    assign rd_addr    = {cmd_shift[5:0], si_s};
    assign wr_data    = {data_rx, si_s};
    assign commit_now = (state == DATA) && sck_rise && (bit_cnt == 6'd31);

    always_comb begin
        rd_data = 24'h000000;
        case (rd_addr)
            7'h00:   rd_data = pin_out;
            7'h01:   rd_data = pin_oe;
            7'h02:   rd_data = pin_rd;
            7'h03:   rd_data = {8'h00, led_data};
            default: rd_data = 24'h000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= cs_s ? IDLE : WAIT_CS;
            bit_cnt    <= 6'd0;
            cmd_shift  <= 7'd0;
            cmd        <= 8'd0;
            data_rx    <= 23'd0;
            stat_shift <= 8'd0;
            data_shift <= 24'd0;
            err_sticky <= 1'b0;
            wr_seen    <= 1'b0;
            pin_out    <= 24'd0;
            pin_oe     <= 24'd0;
            led_data   <= 16'd0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            cfg_so     <= 1'b1;
        end else begin
            wr_strobe <= 1'b0;

            case (state)
                IDLE:    cfg_so <= cs_s ? 1'b1 : stat_shift[7];
                CMD:     cfg_so <= stat_shift[7];
                DATA:    cfg_so <= data_shift[23];
                default: cfg_so <= 1'b1;
            endcase

            // The final data edge wins over a coincident CS rise so the write still lands.
            if (cs_rise && !commit_now) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state      <= CMD;
                        bit_cnt    <= 6'd0;
                        stat_shift <= {STATUS_ID, 2'b00, err_sticky, wr_seen};
                        err_sticky <= 1'b0;
                        wr_seen    <= 1'b0;
                    end
                    CMD: begin
                        if (sck_rise) begin
                            bit_cnt   <= bit_cnt + 6'd1;
                            cmd_shift <= rd_addr;
                            if (bit_cnt == 6'd7) begin
                                cmd        <= {cmd_shift[6], rd_addr};
                                data_shift <= rd_data;
                                state      <= DATA;
                            end
                        end else if (sck_fall && bit_cnt >= 6'd1 && bit_cnt <= 6'd7) begin
                            stat_shift <= {stat_shift[6:0], 1'b0};
                        end
                    end
                    DATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            data_rx <= wr_data[22:0];
                            if (bit_cnt == 6'd31) begin
                                state <= DONE;
                                if (cmd[7]) begin
                                    case (cmd[6:0])
                                        7'h00:   pin_out  <= wr_data;
                                        7'h01:   pin_oe   <= wr_data;
                                        7'h03:   led_data <= wr_data[15:0];
                                        default: ;
                                    endcase
                                    if (cmd[6:0] == 7'h00 || cmd[6:0] == 7'h01 || cmd[6:0] == 7'h03) begin
                                        wr_strobe <= 1'b1;
                                        wr_addr   <= cmd[6:0];
                                        wr_seen   <= 1'b1;
                                    end else begin
                                        err_sticky <= 1'b1;
                                    end
                                end
                            end
                        end else if (sck_fall && bit_cnt >= 6'd9 && bit_cnt <= 6'd31) begin
                            data_shift <= {data_shift[22:0], 1'b0};
                        end
                    end
                    WAIT_CS: if (cs_s) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_pin_regs.sv
// Directed bench for spi_pin_regs: SPI master task, expected-value queue, immediate assertions.
module tb_spi_pin_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_cs, cfg_sck, cfg_si;
    logic        cfg_so;
    logic [23:0] pin_in;
    logic [23:0] pin_out, pin_oe;
    logic [15:0] led_data;
    logic        wr_strobe;
    logic [6:0]  wr_addr;

    int total = 0;
    int bad   = 0;
    int strobe_total = 0;
    int s0;
    logic [39:0] exp_q[$];
    logic [39:0] rx;

    spi_pin_regs #(.SYNC_STAGES(2), .STATUS_ID(4'hA)) dut (
        .clk(clk), .rst(rst),
        .cfg_cs(cfg_cs), .cfg_sck(cfg_sck), .cfg_si(cfg_si), .cfg_so(cfg_so),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .led_data(led_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_total++;

    task automatic push(input logic [39:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [39:0] obs);
        logic [39:0] e;
        total++;
        if (exp_q.size() == 0) e = ~obs;
        else e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master, 12 clk per SCK period; MISO sampled just before each rising edge.
    task automatic spi_frame(input int nbits, input logic [39:0] tx, input bit hold_cs,
                             output logic [39:0] rxo);
        rxo = '0;
        cfg_cs = 1'b0;
        wait_clk(6);
        for (int i = nbits - 1; i >= 0; i--) begin
            cfg_si = tx[i];
            wait_clk(6);
            rxo = {rxo[38:0], cfg_so};
            cfg_sck = 1'b1;
            wait_clk(6);
            cfg_sck = 1'b0;
        end
        wait_clk(6);
        if (!hold_cs) begin
            cfg_cs = 1'b1;
            wait_clk(8);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_cs = 1'b1; cfg_sck = 1'b0; cfg_si = 1'b0; pin_in = 24'h0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        push(0); chk("rst_pin_out", pin_out);
        push(0); chk("rst_pin_oe", pin_oe);
        push(0); chk("rst_led", led_data);
        push(1); chk("rst_so", cfg_so);
        push(0); chk("rst_strobe", wr_strobe);
        push(0); chk("rst_wr_addr", wr_addr);

        // Write pin_oe
        s0 = strobe_total;
        spi_frame(32, {8'h00, 8'h81, 24'hABCDEF}, 1'b0, rx);
        push(8'hA0);      chk("wr_status", rx[31:24]);
        push(24'hABCDEF); chk("wr_pin_oe", pin_oe);
        push(1);          chk("wr_strobes", strobe_total - s0);
        push(7'h01);      chk("wr_addr", wr_addr);

        // Read it back
        s0 = strobe_total;
        spi_frame(32, {8'h00, 8'h01, 24'h000000}, 1'b0, rx);
        push(8'hA1);      chk("rd_status", rx[31:24]);
        push(24'hABCDEF); chk("rd_data", rx[23:0]);
        push(0);          chk("rd_strobes", strobe_total - s0);

        // Read pin_in
        pin_in = 24'h5A5A5A;
        spi_frame(32, {8'h00, 8'h02, 24'h000000}, 1'b0, rx);
        push(8'hA0);      chk("pin_status", rx[31:24]);
        push(24'h5A5A5A); chk("pin_data", rx[23:0]);

        // Write to read-only register
        s0 = strobe_total;
        spi_frame(32, {8'h00, 8'h82, 24'h123456}, 1'b0, rx);
        push(0);          chk("ro_strobes", strobe_total - s0);
        push(24'hABCDEF); chk("ro_pin_oe", pin_oe);
        spi_frame(32, {8'h00, 8'h00, 24'h000000}, 1'b0, rx);
        push(8'hA2);      chk("err_status", rx[31:24]);
        push(24'h000000); chk("rd_pin_out", rx[23:0]);

        // Short frame
        s0 = strobe_total;
        spi_frame(20, 40'h80FFF, 1'b0, rx);
        push(0);          chk("short_strobes", strobe_total - s0);
        push(0);          chk("short_pin_out", pin_out);
        s0 = strobe_total;
        spi_frame(32, {8'h00, 8'h80, 24'h00C0DE}, 1'b0, rx);
        push(8'hA0);      chk("after_short_status", rx[31:24]);
        push(24'h00C0DE); chk("after_short_pin_out", pin_out);
        push(1);          chk("after_short_strobes", strobe_total - s0);

        // Reset mid-frame with CS held low
        s0 = strobe_total;
        spi_frame(12, 40'h83F, 1'b1, rx);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        push(1);          chk("midrst_so", cfg_so);
        push(0);          chk("midrst_led", led_data);
        push(0);          chk("midrst_pin_out", pin_out);
        push(0);          chk("midrst_strobes", strobe_total - s0);
        cfg_cs = 1'b1;
        wait_clk(8);
        s0 = strobe_total;
        spi_frame(32, {8'h00, 8'h83, 24'h00FFFF}, 1'b0, rx);
        push(16'hFFFF);   chk("led_write", led_data);
        push(1);          chk("led_strobes", strobe_total - s0);
        push(7'h03);      chk("led_wr_addr", wr_addr);

        // Long frame with 8 junk bits
        s0 = strobe_total;
        spi_frame(40, {8'h80, 24'h123456, 8'hA5}, 1'b0, rx);
        push(24'h123456); chk("long_pin_out", pin_out);
        push(1);          chk("long_strobes", strobe_total - s0);
        push(8'hFF);      chk("long_junk_so", rx[7:0]);
        push(16'hFFFF);   chk("long_led_kept", led_data);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
